// File: rtl/registers.sv
// registers: 32x32 register file, two combinational read ports, one clocked write port.
// The write port takes rd/opcode from the instruction; MOV copies R[rs], other opcodes write data.
module registers (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] instruction,
  input  logic [4:0]  address1,
  input  logic [4:0]  address2,
  input  logic        enable_write,
  input  logic        enable_read,
  output logic [31:0] data_out1,
  output logic [31:0] data_out2
);
  localparam logic [4:0] OP_MOV = 5'b00010;
  logic [31:0] r [32];
  logic [4:0]  opcode, rd, rs;
  logic [31:0] wdata;
  logic        unused_bits;
  assign opcode      = instruction[31:27];
  assign rd          = instruction[26:22];
  assign rs          = instruction[4:0];
  assign unused_bits = ^instruction[21:5];
  assign wdata       = opcode == OP_MOV ? r[rs] : data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r[i] <= '0;
    end else if (enable_write) begin
      r[rd] <= wdata;
    end
  end
  assign data_out1 = enable_read ? r[address1] : '0;
  assign data_out2 = enable_read ? r[address2] : '0;
endmodule

// File: tb/tb_registers.sv
// tb_registers: scoreboard bench for the register file.
module tb_registers;
  logic        clk = 0;
  logic        rst_n;
  logic [31:0] data, instruction;
  logic [4:0]  address1, address2;
  logic        enable_write, enable_read;
  logic [31:0] data_out1, data_out2;
  logic [31:0] m [32];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  registers dut (
    .clk(clk), .rst_n(rst_n), .data(data), .instruction(instruction),
    .address1(address1), .address2(address2), .enable_write(enable_write),
    .enable_read(enable_read), .data_out1(data_out1), .data_out2(data_out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a1, input logic [4:0] a2, input logic en);
    address1 = a1;
    address2 = a2;
    enable_read = en;
    exp_q.push_back(en ? m[a1] : 32'h0);
    exp_q.push_back(en ? m[a2] : 32'h0);
    #1;
    check({tag, "/p1"}, data_out1, exp_q.pop_front());
    check({tag, "/p2"}, data_out2, exp_q.pop_front());
  endtask

  // Unused instruction bits are randomised to show they are ignored.
  task automatic wr(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                    input logic [31:0] d, input logic we);
    logic [31:0] nv;
    @(negedge clk);
    instruction = {op, rd, 17'($urandom), rs};
    data = d;
    enable_write = we;
    nv = op == 5'b00010 ? m[rs] : d;
    @(posedge clk);
    #1;
    if (we) m[rd] = nv;
    enable_write = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    rst_n = 0;
    enable_write = 1;
    enable_read = 1;
    data = 32'hFFFF_FFFF;
    instruction = 32'h0;
    address1 = 0;
    address2 = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1;
    enable_write = 0;
    for (int i = 0; i < 32; i++) rd_chk("reset", 5'(i), 5'(31 - i), 1);

    wr(5'd0, 5'd0, 5'd0, 32'h7, 1);
    rd_chk("lw", 5'd0, 5'd1, 1);
    check("lw_r0", data_out1, 32'h7);

    wr(5'd0, 5'd5, 5'd0, 32'h55, 1);
    @(negedge clk);
    instruction = 32'h10C00005;
    data = 32'h1234_5678;
    enable_write = 1;
    @(posedge clk);
    #1;
    m[3] = 32'h55;
    enable_write = 0;
    rd_chk("mov", 5'd5, 5'd3, 1);
    check("mov_rd", data_out2, 32'h55);
    check("mov_rs", data_out1, 32'h55);

    wr(5'd2, 5'd5, 5'd5, 32'h0, 1);
    rd_chk("mov_self", 5'd5, 5'd5, 1);

    wr(5'd3, 5'd0, 5'd0, 32'h1800_000A, 1);
    rd_chk("add", 5'd0, 5'd0, 1);
    check("add_r0", data_out1, 32'h1800_000A);

    wr(5'd0, 5'd7, 5'd0, 32'hDEAD_BEEF, 1);
    wr(5'd0, 5'd7, 5'd0, 32'h1111_2222, 0);
    rd_chk("we_off", 5'd7, 5'd7, 1);
    check("we_off_r7", data_out1, 32'hDEAD_BEEF);

    for (int i = 0; i < 32; i += 5) rd_chk("re_off", 5'(i), 5'(i + 2), 0);

    wr(5'd0, 5'd31, 5'd0, 32'h0000_1234, 1);
    @(negedge clk);
    rst_n = 0;
    instruction = {5'd0, 5'd31, 22'h0};
    data = 32'hFFFF_FFFF;
    enable_write = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    enable_write = 0;
    rst_n = 1;
    rd_chk("rst_pri", 5'd31, 5'd7, 1);

    @(negedge clk);
    address1 = 5'd31;
    enable_read = 1;
    instruction = {5'd0, 5'd31, 22'h0};
    data = 32'hA5A5_A5A5;
    enable_write = 1;
    #1;
    check("bypass_before", data_out1, 32'h0);
    @(posedge clk);
    #1;
    enable_write = 0;
    check("bypass_after", data_out1, 32'hA5A5_A5A5);
    m[31] = 32'hA5A5_A5A5;

    for (int k = 0; k < 300; k++) begin
      wr($urandom_range(0, 3) == 0 ? 5'd2 : 5'($urandom), 5'($urandom), 5'($urandom),
         $urandom, $urandom_range(0, 3) != 0);
      rd_chk("rand", 5'($urandom), 5'($urandom), $urandom_range(0, 7) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
